// File: rtl/cnt_pkg.sv
// cont_updown shared types.
// Counting mode encoding for the up/down counter.
package cnt_pkg;

  typedef enum logic [1:0] {
    UP_WRAP   = 2'b00,
    DOWN_WRAP = 2'b01,
    BOUNCE    = 2'b10,
    HOLD      = 2'b11
  } cnt_mode_t;

endpackage

// File: rtl/cont_updown_if.sv
// cont_updown control/status bundle.
// master drives controls and bounds, slave returns count state.
interface cont_updown_if #(
  parameter int WIDTH = 4
);
  import cnt_pkg::*;

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  cnt_mode_t        mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;

  modport master (
    output en, load, load_val, mode, lo, hi,
    input  count, dir, tc
  );

  modport slave (
    input  en, load, load_val, mode, lo, hi,
    output count, dir, tc
  );

endinterface

// File: rtl/cont_step.sv
// cont_updown next-state function.
// Assumes lo < hi and lo <= count <= hi; bounds are handled first.
module cont_step
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  cnt_mode_t        mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] nxt_count,
  output logic             nxt_dir,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = 1;

  always_comb begin
    nxt_count = count;
    nxt_dir   = dir;
    wrap      = 1'b0;
    unique case (mode)
      UP_WRAP: begin
        nxt_dir = 1'b0;
        if (count == hi) begin
          nxt_count = lo;
          wrap      = 1'b1;
        end else begin
          nxt_count = count + ONE;
        end
      end
      DOWN_WRAP: begin
        nxt_dir = 1'b1;
        if (count == lo) begin
          nxt_count = hi;
          wrap      = 1'b1;
        end else begin
          nxt_count = count - ONE;
        end
      end
      BOUNCE: begin
        if (!dir) begin
          if (count == hi) begin
            nxt_count = hi - ONE;
            nxt_dir   = 1'b1;
            wrap      = 1'b1;
          end else begin
            nxt_count = count + ONE;
          end
        end else begin
          if (count == lo) begin
            nxt_count = lo + ONE;
            nxt_dir   = 1'b0;
            wrap      = 1'b1;
          end else begin
            nxt_count = count - ONE;
          end
        end
      end
      HOLD: begin
        nxt_count = count;
      end
    endcase
  end

endmodule

// File: rtl/cont_updown.sv
// cont_updown: bounded up/down counter with wrap/bounce modes.
// Priority: load > degenerate bounds > out-of-range > step > hold.
module cont_updown
  import cnt_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic         clk,
  input logic         rst,
  cont_updown_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] step_count;
  logic             step_dir;
  logic             step_wrap;
  logic             degen;
  logic             oor;

  cont_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .count     (count_q),
    .dir       (dir_q),
    .mode      (bus.mode),
    .lo        (bus.lo),
    .hi        (bus.hi),
    .nxt_count (step_count),
    .nxt_dir   (step_dir),
    .wrap      (step_wrap)
  );

  assign degen = (bus.hi <= bus.lo);
  assign oor   = (count_q < bus.lo) || (count_q > bus.hi);

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.en) begin
      if (degen || oor) begin
        count_d = bus.lo;
        dir_d   = 1'b0;
      end else begin
        count_d = step_count;
        dir_d   = step_dir;
        tc_d    = step_wrap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_VAL;
      dir_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.tc    = tc_q;

endmodule

// File: tb/tb_cont_updown.sv
// Directed bench for cont_updown.
// Runs a 4-bit and an 8-bit instance against hand-computed vectors.
module tb_cont_updown;
  import cnt_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  cont_updown_if #(.WIDTH(4)) b4 ();
  cont_updown_if #(.WIDTH(8)) b8 ();

  cont_updown #(
    .WIDTH   (4),
    .RST_VAL (4'd0)
  ) u4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  cont_updown #(
    .WIDTH   (8),
    .RST_VAL (8'd0)
  ) u8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    assert (act === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
  endtask

  task automatic chk4(input string tag, input int c,
                      input logic d, input logic t);
    chk({tag, ".count"}, 32'(b4.count), 32'(c));
    chk({tag, ".dir"}, 32'(b4.dir), 32'(d));
    chk({tag, ".tc"}, 32'(b4.tc), 32'(t));
  endtask

  task automatic chk8(input string tag, input int c,
                      input logic d, input logic t);
    chk({tag, ".count"}, 32'(b8.count), 32'(c));
    chk({tag, ".dir"}, 32'(b8.dir), 32'(d));
    chk({tag, ".tc"}, 32'(b8.tc), 32'(t));
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b0;
    b4.en = 1'b0; b4.load = 1'b0; b4.load_val = '0;
    b4.mode = BOUNCE; b4.lo = 4'd0; b4.hi = 4'd15;
    b8.en = 1'b0; b8.load = 1'b0; b8.load_val = '0;
    b8.mode = BOUNCE; b8.lo = 8'd0; b8.hi = 8'd255;
    tick();
    tick();
    chk4("reset", 0, 1'b0, 1'b0);
    chk8("reset8", 0, 1'b0, 1'b0);

    // full bounce 0..15..0,1
    rst = 1'b1;
    b4.en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk4($sformatf("bup%0d", i), i, 1'b0, 1'b0);
    end
    for (int i = 14; i >= 0; i--) begin
      tick();
      chk4($sformatf("bdn%0d", i), i, 1'b1, 1'(i == 14));
    end
    tick();
    chk4("bturn", 1, 1'b0, 1'b1);

    // up-wrap 3..6 from load 5
    b4.mode = UP_WRAP; b4.lo = 4'd3; b4.hi = 4'd6;
    b4.load = 1'b1; b4.load_val = 4'd5;
    tick(); chk4("uwld", 5, 1'b0, 1'b0);
    b4.load = 1'b0;
    tick(); chk4("uw6a", 6, 1'b0, 1'b0);
    tick(); chk4("uw3a", 3, 1'b0, 1'b1);
    tick(); chk4("uw4", 4, 1'b0, 1'b0);
    tick(); chk4("uw5", 5, 1'b0, 1'b0);
    tick(); chk4("uw6b", 6, 1'b0, 1'b0);
    tick(); chk4("uw3b", 3, 1'b0, 1'b1);
    tick(); chk4("uw4b", 4, 1'b0, 1'b0);
    b4.mode = DOWN_WRAP;
    tick(); chk4("dw3", 3, 1'b1, 1'b0);
    tick(); chk4("dw6", 6, 1'b1, 1'b1);
    tick(); chk4("dw5", 5, 1'b1, 1'b0);

    // out-of-range recovery
    rst = 1'b0;
    tick();
    rst = 1'b1;
    b4.mode = BOUNCE; b4.lo = 4'd2; b4.hi = 4'd9;
    tick(); chk4("oor_rst", 2, 1'b0, 1'b0);
    b4.load = 1'b1; b4.load_val = 4'd12;
    tick(); chk4("ld12", 12, 1'b0, 1'b0);
    b4.load = 1'b0;
    tick(); chk4("oor_ld", 2, 1'b0, 1'b0);
    for (int i = 3; i <= 7; i++) begin
      tick();
      chk4($sformatf("b2_%0d", i), i, 1'b0, 1'b0);
    end
    b4.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4($sformatf("hold%0d", i), 7, 1'b0, 1'b0);
    end
    b4.en = 1'b1;
    tick(); chk4("reen", 8, 1'b0, 1'b0);
    b4.load = 1'b1; b4.load_val = 4'd4;
    tick(); chk4("ldwin", 4, 1'b0, 1'b0);

    // async reset mid-count
    b4.load = 1'b0;
    b4.mode = DOWN_WRAP; b4.lo = 4'd0; b4.hi = 4'd15;
    tick(); chk4("dwset", 3, 1'b1, 1'b0);
    b4.load = 1'b1; b4.load_val = 4'd11;
    tick(); chk4("ld11", 11, 1'b1, 1'b0);
    b4.load = 1'b0;
    b4.mode = BOUNCE;
    #2;
    rst = 1'b0;
    #1;
    chk4("arst", 0, 1'b0, 1'b0);
    tick(); chk4("arst_h1", 0, 1'b0, 1'b0);
    tick(); chk4("arst_h2", 0, 1'b0, 1'b0);
    rst = 1'b1;
    b4.mode = UP_WRAP; b4.lo = 4'd5; b4.hi = 4'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk4($sformatf("degen%0d", i), 5, 1'b0, 1'b0);
    end

    // 8-bit extremes
    b8.en = 1'b1; b8.load = 1'b1; b8.load_val = 8'd253;
    tick(); chk8("w8ld", 253, 1'b0, 1'b0);
    b8.load = 1'b0;
    tick(); chk8("w8_254", 254, 1'b0, 1'b0);
    tick(); chk8("w8_255", 255, 1'b0, 1'b0);
    tick(); chk8("w8_rev", 254, 1'b1, 1'b1);
    tick(); chk8("w8_253", 253, 1'b1, 1'b0);
    b8.load = 1'b1; b8.load_val = 8'd1;
    tick(); chk8("w8ld1", 1, 1'b1, 1'b0);
    b8.load = 1'b0;
    tick(); chk8("w8_0", 0, 1'b1, 1'b0);
    tick(); chk8("w8_1", 1, 1'b0, 1'b1);
    tick(); chk8("w8_2", 2, 1'b0, 1'b0);
    b8.mode = UP_WRAP;
    b8.load = 1'b1; b8.load_val = 8'd254;
    tick(); chk8("u8ld", 254, 1'b0, 1'b0);
    b8.load = 1'b0;
    tick(); chk8("u8_255", 255, 1'b0, 1'b0);
    tick(); chk8("u8_0", 0, 1'b0, 1'b1);
    tick(); chk8("u8_1", 1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cont_updown.md
# cont_updown

Parametrised up/down counter that succeeds the fixed 4-bit bounce counter. It adds runtime bounds, selectable wrap or bounce modes, clock-enable, synchronous load and a terminal-count pulse. It sits in the timing/sequencing layer and drives pattern generators, PWM sweeps and sequencers that previously needed a dedicated fixed counter per width.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥2)
- RST_VAL, 0, count value after reset (WIDTH bits)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, asynchronous assert, active-low (rst=0 resets)
- en  in  1  step enable; no step when 0
- load  in  1  synchronous load; overrides en
- load_val  in  WIDTH  value written on load
- mode  in  2  cnt_mode_t: 00 UP_WRAP, 01 DOWN_WRAP, 10 BOUNCE, 11 HOLD
- lo  in  WIDTH  lower bound, inclusive, unsigned
- hi  in  WIDTH  upper bound, inclusive, unsigned
- count  out  WIDTH  current count, registered
- dir  out  1  current direction, 0=up 1=down, registered
- tc  out  1  one-cycle terminal-count pulse, registered

## Operation
- Reset (rst=0, any time, including mid-count): count=RST_VAL, dir=0, tc=0, held while rst=0.
- Per-edge priority: load > (hi≤lo) > out-of-range > en step > hold.
- load=1: count=load_val, dir unchanged, tc=0. load_val is not range-checked.
- hi≤lo with en=1 and load=0: count=lo, dir=0, tc=0. The block is degenerate and holds at lo.
- Out of range (count<lo or count>hi) with en=1: count=lo, dir=0, tc=0. This covers reset value, load_val or bounds moved outside the current count.
- en=0, or mode=HOLD: all state holds and tc=0.
- UP_WRAP: dir forced 0. If count==hi, count=lo and tc=1. Otherwise count+1.
- DOWN_WRAP: dir forced 1. If count==lo, count=hi and tc=1. Otherwise count−1.
- BOUNCE, dir=0: if count==hi, count=hi−1, dir=1, tc=1. Otherwise count+1.
- BOUNCE, dir=1: if count==lo, count=lo+1, dir=0, tc=1. Otherwise count−1.
- Each bound appears exactly once per reversal. For lo=0, hi=15 the sequence is 0,1..15,14..0,1.
- Arithmetic is WIDTH-bit unsigned. No step ever crosses 0 or 2^WIDTH−1, because every bound is handled before the increment or decrement.
- A mode change mid-count takes effect on the next enabled edge from the current count. In the wrap modes dir is overwritten.

## Timing
- All outputs are registered and update on the rising clk edge; there are no combinational input-to-output paths.
- Latency is one cycle: count, dir and tc reflect the inputs sampled at the previous edge.
- tc is high for exactly one cycle, the cycle in which count shows the post-wrap or post-reversal value. It is never high for two consecutive cycles unless two consecutive enabled steps each wrap (hi==lo+1 in BOUNCE).
- lo, hi and mode are sampled each edge; there is no shadowing.
- Reset deassertion is synchronised externally. The first step occurs on the first edge with rst=1 and en=1.

## Structure
- Package cnt_pkg holds the typedef enum logic [1:0] cnt_mode_t {UP_WRAP, DOWN_WRAP, BOUNCE, HOLD}.
- Sub-module cont_step: purely combinational next-state function with inputs count, dir, mode, lo, hi and outputs nxt_count, nxt_dir, wrap.
- Top level: input priority mux plus the count, dir and tc registers.

## Test plan
- WIDTH=4, lo=0, hi=15, BOUNCE, en=1 after reset (RST_VAL=0) -> count 0,1..15,14..0,1. dir flips on the cycle count=14 after 15. tc=1 exactly at count=14 (down leg) and count=1 (up leg).
- UP_WRAP, lo=3, hi=6, load_val=5 loaded -> 5,6,3,4,5,6,3. tc=1 at each 3 following 6. DOWN_WRAP from 4 -> 4,3,6,5. dir=1.
- BOUNCE, lo=2, hi=9, count=0 after reset, en=1 -> next count=2, dir=0, tc=0. Then load_val=12 is loaded, and the next enabled step gives count=2.
- Toggle en=0 for 3 cycles at count=7 going up -> count stays 7 and tc=0. Re-enable -> 8. load and en together at count=8 with load_val=4 -> 4 (load wins).
- Assert rst=0 asynchronously between edges at count=11, dir=1 -> count=RST_VAL, dir=0 and tc=0 immediately, held while rst=0. lo=hi=5 with en=1 -> count pinned at 5, tc never set.
- WIDTH=8, lo=0, hi=255, BOUNCE -> 255 is followed by 254 and 0 by 1, with no overflow. UP_WRAP 255 -> 0 with tc=1.
